// File: rtl/ccx_ser_pkg.sv
// ----------------------------------------------------------------------------
// ccx_ser_pkg
// Shared definitions for the PCX-to-Maxeler serializer:
//   - packet/frame geometry (PCX_WIDTH, FRAME_WORDS)
//   - W0 field offsets (DEST_LSB, ATOM_BIT)
//   - FSM state enum
//   - buffered entry struct {dest, atom, data} (130 bits)
//   - frame_word(): builds frame word 0..4 from a buffered entry
// ----------------------------------------------------------------------------
package ccx_ser_pkg;

    localparam int PCX_WIDTH   = 124;
    localparam int FRAME_WORDS = 5;
    localparam int DEST_W      = 5;
    localparam int DEST_LSB    = 0;
    localparam int ATOM_BIT    = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_PAIR = 2'd1,
        ST_SEND      = 2'd2
    } pcx_state_e;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic                 atom;
        logic [PCX_WIDTH-1:0] data;
    } pcx_entry_t;

    localparam int ENTRY_W = $bits(pcx_entry_t);

    // Word 0 carries only the routing header; words 1..4 carry the payload
    // most-significant first, with the 28-bit top slice zero-extended.
    function automatic logic [31:0] frame_word(input pcx_entry_t e, input logic [2:0] idx);
        logic [31:0] w;
        w = '0;
        case (idx)
            3'd0: begin
                w[DEST_LSB +: DEST_W] = e.dest;
                w[ATOM_BIT]           = e.atom;
            end
            3'd1:    w = {4'h0, e.data[123:96]};
            3'd2:    w = e.data[95:64];
            3'd3:    w = e.data[63:32];
            3'd4:    w = e.data[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pcx_ser_fifo.sv
// ----------------------------------------------------------------------------
// pcx_ser_fifo
// Synchronous first-word-fall-through FIFO for serializer entries.
// Pointers are log2(DEPTH)+1 bits; the MSB is the wrap bit that separates
// full from empty. Writes while full and reads while empty are ignored.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (pointers only)
//   push, wr_data write request and entry
//   pop          advance read pointer
//   rd_data      head entry (valid when !empty)
//   rd_data_nxt  entry behind the head (valid when count >= 2)
//   count, full, empty  occupancy status
// ----------------------------------------------------------------------------
module pcx_ser_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 130,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_data_nxt,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign rd_ptr_nxt = rd_ptr + PTR_ONE;
    assign count      = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data     = mem[rd_ptr[AW-1:0]];
    assign rd_data_nxt = mem[rd_ptr_nxt[AW-1:0]];

endmodule

// File: rtl/pcx2max_ser.sv
// ----------------------------------------------------------------------------
// pcx2max_ser
// Serializes 124-bit SPARC PCX requests into fixed 5-word 32-bit frames.
// A request (PQ) latches dest/atom; the payload arrives next cycle (PA) and
// the entry is pushed into pcx_ser_fifo. Frames leave under valid/stall, and
// a one-cycle grant pulse for the frame's destination follows its last word.
// Optional build macro: PCX_SER_ATOMIC_EN -- an atomic head entry waits in
// WAIT_PAIR until its partner is buffered, then both go out back-to-back.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   spc_pcx_req_pq     one-hot destination request (PQ)
//   spc_pcx_atom_pq    atomic-pair flag (PQ)
//   spc_pcx_data_pa    payload (PA, cycle after request)
//   pcx_spc_grant_px   per-destination grant pulse
//   pcx_valid/pcx_data registered output word, pcx_stall backpressure
//   ovf_err            sticky: push while full or non-one-hot request
// ----------------------------------------------------------------------------
module pcx2max_ser
    import ccx_ser_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           spc_pcx_req_pq,
    input  logic                 spc_pcx_atom_pq,
    input  logic [PCX_WIDTH-1:0] spc_pcx_data_pa,
    output logic [4:0]           pcx_spc_grant_px,
    output logic                 pcx_valid,
    input  logic                 pcx_stall,
    output logic [31:0]          pcx_data,
    output logic                 ovf_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;
    localparam logic [2:0]  LAST_IDX = 3'(FRAME_WORDS - 1);
    localparam logic [AW:0] CNT_TWO  = 2;

    logic              vld_p0;
    logic [DEST_W-1:0] dest_p0;
    logic              atom_p0;

    pcx_entry_t  inc_entry;
    pcx_entry_t  head;
    pcx_entry_t  head_nxt;
    pcx_entry_t  cand;
    logic [AW:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_acc;
    logic        pop;

    pcx_state_e  state, state_n;
    logic [2:0]  idx, idx_n;
    logic        valid_n;
    logic [31:0] data_n;
    logic [4:0]  grant_n;
    logic        pair_pend, pair_n;
    logic        xfer;
    logic [CW-1:0] avail;
    logic        start_ok;
    logic        hold_pair;
    logic        pair_first;
    logic        bad_req;

    // ---- PQ stage: latch request header ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= |spc_pcx_req_pq;
    end

    always_ff @(posedge clk) begin
        dest_p0 <= spc_pcx_req_pq;
        atom_p0 <= spc_pcx_atom_pq;
    end

    // ---- PA stage: assemble entry and push ----
    assign inc_entry = {dest_p0, atom_p0, spc_pcx_data_pa};
    assign push_acc  = vld_p0 && !fifo_full;
    assign bad_req   = vld_p0 && ((dest_p0 & (dest_p0 - 5'd1)) != 5'd0);

    pcx_ser_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push_acc),
        .wr_data     (inc_entry),
        .pop         (pop),
        .rd_data     (head),
        .rd_data_nxt (head_nxt),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // ---- output stage: frame sequencing ----
    assign xfer = pcx_valid && !pcx_stall;

    // The entry that would start next. While a frame is in flight its entry
    // is still the FIFO head, so the successor is one slot behind; an entry
    // being pushed this cycle is bypassed so an idle block starts at once.
    always_comb begin
        if (state == ST_SEND) begin
            cand  = (fifo_count >= CNT_TWO) ? head_nxt : inc_entry;
            avail = CW'(fifo_count) + CW'(push_acc) - CW'(1);
        end else begin
            cand  = fifo_empty ? inc_entry : head;
            avail = CW'(fifo_count) + CW'(push_acc);
        end
    end

`ifdef PCX_SER_ATOMIC_EN
    // An atomic entry starts only with its partner buffered; the partner
    // itself always follows unconditionally, whatever its own atom flag.
    always_comb begin
        if (avail == '0)                   start_ok = 1'b0;
        else if (pair_pend || !cand.atom)  start_ok = 1'b1;
        else                               start_ok = (avail >= CW'(2));
        hold_pair  = (avail != '0) && !start_ok;
        pair_first = !pair_pend && cand.atom;
    end
`else
    assign start_ok   = (avail != '0);
    assign hold_pair  = 1'b0;
    assign pair_first = 1'b0;
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx;
        valid_n = pcx_valid;
        data_n  = pcx_data;
        grant_n = '0;
        pair_n  = pair_pend;
        pop     = 1'b0;
        if (state == ST_SEND) begin
            if (xfer) begin
                if (idx != LAST_IDX) begin
                    idx_n  = idx + 3'd1;
                    data_n = frame_word(head, idx + 3'd1);
                end else begin
                    pop     = 1'b1;
                    grant_n = head.dest;
                    idx_n   = '0;
                    if (start_ok) begin
                        valid_n = 1'b1;
                        data_n  = frame_word(cand, 3'd0);
                        pair_n  = pair_first;
                    end else begin
                        valid_n = 1'b0;
                        data_n  = '0;
                        pair_n  = 1'b0;
                        state_n = hold_pair ? ST_WAIT_PAIR : ST_IDLE;
                    end
                end
            end
        end else begin
            if (start_ok) begin
                state_n = ST_SEND;
                idx_n   = '0;
                valid_n = 1'b1;
                data_n  = frame_word(cand, 3'd0);
                pair_n  = pair_first;
            end else begin
                state_n = hold_pair ? ST_WAIT_PAIR : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            idx              <= '0;
            pcx_valid        <= 1'b0;
            pcx_data         <= '0;
            pcx_spc_grant_px <= '0;
            pair_pend        <= 1'b0;
            ovf_err          <= 1'b0;
        end else begin
            state            <= state_n;
            idx              <= idx_n;
            pcx_valid        <= valid_n;
            pcx_data         <= data_n;
            pcx_spc_grant_px <= grant_n;
            pair_pend        <= pair_n;
            if ((vld_p0 && fifo_full) || bad_req) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pcx2max_ser.sv
// ----------------------------------------------------------------------------
// tb_pcx2max_ser
// Scoreboard bench for pcx2max_ser. Requests push their expected frame words
// and grant into queues; a negedge monitor pops and compares whatever the
// DUT transfers. Directed cases cover latency, stall, back-to-back, atomic
// pairing, overflow and reset mid-frame; a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_pcx2max_ser;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   spc_pcx_req_pq;
    logic         spc_pcx_atom_pq;
    logic [123:0] spc_pcx_data_pa;
    logic [4:0]   pcx_spc_grant_px;
    logic         pcx_valid;
    logic         pcx_stall;
    logic [31:0]  pcx_data;
    logic         ovf_err;

    pcx2max_ser #(.FIFO_DEPTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .spc_pcx_req_pq   (spc_pcx_req_pq),
        .spc_pcx_atom_pq  (spc_pcx_atom_pq),
        .spc_pcx_data_pa  (spc_pcx_data_pa),
        .pcx_spc_grant_px (pcx_spc_grant_px),
        .pcx_valid        (pcx_valid),
        .pcx_stall        (pcx_stall),
        .pcx_data         (pcx_data),
        .ovf_err          (ovf_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int occ    = 0;
    int first_cyc = -1;
    bit arm_first = 0;
    int w4_cyc    = -100;
    int last_gcyc = -1;
    int prev_gcyc = -1;
    int word_in_frame = 0;
    bit prev_stalled  = 0;
    logic [31:0]  prev_data;
    logic [31:0]  exp_w;
    logic [4:0]   exp_g;
    logic [123:0] pa_hold = '0;
    logic [31:0]  wq[$];
    logic [4:0]   gq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [123:0] rnd124();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[123:0];
    endfunction

    // Reference: a FIFO of 16 packets; the 17th outstanding one is lost.
    task automatic model_push(input logic [4:0] d, input logic a, input logic [123:0] p);
        if (occ < 16) begin
            occ++;
            wq.push_back({24'h0, 2'b00, a, d});
            wq.push_back({4'h0, p[123:96]});
            wq.push_back(p[95:64]);
            wq.push_back(p[63:32]);
            wq.push_back(p[31:0]);
            gq.push_back(d);
        end
    endtask

    // One cycle: request fields now, payload of the previous request now.
    task automatic step(input logic [4:0] r, input logic a, input logic [123:0] d);
        spc_pcx_req_pq  = r;
        spc_pcx_atom_pq = a;
        spc_pcx_data_pa = pa_hold;
        pa_hold         = d;
        if (r != 5'd0) model_push(r, a, d);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(5'd0, 1'b0, rnd124());
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        pcx_stall = 1'b0;
        while ((wq.size() != 0 || gq.size() != 0) && k < limit) begin
            idle();
            k++;
        end
        n_cmp++;
        if (wq.size() != 0 || gq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: words left %0d grants left %0d, required 0", wq.size(), gq.size());
        end
        idle();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stalled  = 0;
            word_in_frame = 0;
        end else begin
            if (prev_stalled) begin
                n_cmp++;
                if (!(pcx_valid === 1'b1 && pcx_data === prev_data)) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid %0b data %0h, required 1 %0h", pcx_valid, pcx_data, prev_data);
                end
            end
            prev_stalled = pcx_valid && pcx_stall;
            prev_data    = pcx_data;
            if (pcx_valid && arm_first) begin
                first_cyc = cyc;
                arm_first = 0;
            end
            if (pcx_valid && !pcx_stall) begin
                n_cmp++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, required none", pcx_data);
                end else begin
                    exp_w = wq.pop_front();
                    if (pcx_data !== exp_w) begin
                        n_fail++;
                        $display("FAIL word: got %0h required %0h (cycle %0d)", pcx_data, exp_w, cyc);
                    end
                end
                word_in_frame++;
                if (word_in_frame == 5) begin
                    word_in_frame = 0;
                    occ--;
                    w4_cyc = cyc;
                end
            end
            if (pcx_spc_grant_px != 5'd0) begin
                n_cmp++;
                if (gq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_grant: got %0b, required none", pcx_spc_grant_px);
                end else begin
                    exp_g = gq.pop_front();
                    if (pcx_spc_grant_px !== exp_g) begin
                        n_fail++;
                        $display("FAIL grant: got %0b required %0b", pcx_spc_grant_px, exp_g);
                    end
                end
                n_cmp++;
                if (cyc != w4_cyc + 1) begin
                    n_fail++;
                    $display("FAIL grant_timing: grant cycle %0d, required %0d", cyc, w4_cyc + 1);
                end
                prev_gcyc = last_gcyc;
                last_gcyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [4:0] d5;
        int guard;
        rst = 1'b1;
        pcx_stall = 1'b0;
        spc_pcx_req_pq = '0;
        spc_pcx_atom_pq = 1'b0;
        spc_pcx_data_pa = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", pcx_valid, 1'b0);
        chk("reset_data", pcx_data, 32'h0);
        chk("reset_grant", pcx_spc_grant_px, 5'h0);
        chk("reset_ovf", ovf_err, 1'b0);
        rst = 1'b0;
        idle();

        // single packet, unstalled
        arm_first = 1;
        n0 = cyc;
        step(5'b00001, 1'b0, 124'h123456789ABCDEF0123456789ABCDEF);
        drain(40);
        chk("single_first_word_cycle", first_cyc, n0 + 2);
        chk("single_grant_cycle", last_gcyc, n0 + 7);

        // stall for 3 cycles while W2 is presented
        arm_first = 1;
        n0 = cyc;
        step(5'b00100, 1'b0, rnd124());
        repeat (3) idle();
        pcx_stall = 1'b1;
        repeat (3) idle();
        pcx_stall = 1'b0;
        drain(40);
        chk("stall_first_word_cycle", first_cyc, n0 + 2);
        chk("stall_grant_cycle", last_gcyc, n0 + 10);

        // back-to-back
        n0 = cyc;
        step(5'b00010, 1'b0, rnd124());
        step(5'b10000, 1'b0, rnd124());
        drain(40);
        chk("b2b_grant1_cycle", prev_gcyc, n0 + 7);
        chk("b2b_grant2_cycle", last_gcyc, n0 + 12);

        // atomic pair
        arm_first = 1;
        n0 = cyc;
        step(5'b00001, 1'b1, rnd124());
        repeat (3) idle();
        step(5'b00100, 1'b0, rnd124());
        drain(40);
`ifdef PCX_SER_ATOMIC_EN
        chk("atomic_first_word_cycle", first_cyc, n0 + 6);
        chk("atomic_grant2_cycle", last_gcyc, n0 + 16);
`else
        chk("atomic_first_word_cycle", first_cyc, n0 + 2);
        chk("atomic_grant2_cycle", last_gcyc, n0 + 12);
`endif

        // randomized traffic with random stalls, credit-limited
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                pcx_stall = ($urandom_range(0, 9) < 3);
                idle();
            end
            guard = 0;
            while (occ >= 10 && guard < 500) begin
                pcx_stall = ($urandom_range(0, 9) < 3);
                idle();
                guard++;
            end
            pcx_stall = ($urandom_range(0, 9) < 3);
            d5 = '0;
            d5[$urandom_range(0, 4)] = 1'b1;
            step(d5, 1'b0, rnd124());
        end
        drain(3000);
        chk("random_no_ovf", ovf_err, 1'b0);

        // overflow: 17 requests into a stalled output
        pcx_stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            d5 = '0;
            d5[i % 5] = 1'b1;
            step(d5, 1'b0, rnd124());
        end
        chk("ovf_before_17th_push", ovf_err, 1'b0);
        idle();
        chk("ovf_after_17th_push", ovf_err, 1'b1);
        drain(300);
        chk("ovf_sticky", ovf_err, 1'b1);

        // reset during W3
        n0 = cyc;
        step(5'b01000, 1'b0, rnd124());
        repeat (4) idle();
        chk("w3_presented", pcx_valid, 1'b1);
        rst = 1'b1;
        wq.delete();
        gq.delete();
        occ = 0;
        #1;
        chk("midreset_valid", pcx_valid, 1'b0);
        chk("midreset_grant", pcx_spc_grant_px, 5'h0);
        chk("midreset_ovf", ovf_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) idle();
        chk("post_reset_quiet", pcx_valid, 1'b0);

        // fresh packet after reset
        arm_first = 1;
        n0 = cyc;
        step(5'b10000, 1'b0, rnd124());
        drain(40);
        chk("post_reset_first_word_cycle", first_cyc, n0 + 2);
        chk("post_reset_ovf", ovf_err, 1'b0);

        // non-one-hot request is still forwarded and flags the error
        step(5'b00011, 1'b0, rnd124());
        drain(40);
        chk("nonhot_ovf", ovf_err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
